parity_pkt_ctrl: RTL and testbench
==================================

PARITY_PKT_CTRL -- requirements
Module: parity_pkt_ctrl

Interface
REQ-001 SHALL have parameter PKT_LEN, default 4, bytes per packet; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 8, width of the cumulative error counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream byte valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a byte.
REQ-007 SHALL have port in_data, input, 8, received data byte.
REQ-008 SHALL have port in_par, input, 1, received parity bit.
REQ-009 SHALL have port clr_cnt, input, 1, clears err_cnt.
REQ-010 SHALL have port out_valid, output, 1, one-cycle strobe for a checked byte.
REQ-011 SHALL have port out_data, output, 8, checked byte, passed through unchanged.
REQ-012 SHALL have port out_par, output, 1, regenerated odd-parity bit for out_data.
REQ-013 SHALL have port out_err, output, 1, parity mismatch on this byte.
REQ-014 SHALL have port pkt_done, output, 1, one-cycle end-of-packet strobe.
REQ-015 SHALL have port pkt_err, output, 1, at least one byte in the packet just finished was bad; valid with pkt_done.
REQ-016 SHALL have port err_cnt, output, CNT_W, saturating count of bad bytes across packets.
REQ-017 SHALL have port busy, output, 1, packet in progress (state not IDLE).

Function
REQ-018 Parity convention SHALL be odd: out_par = ~^in_data; byte error = (in_par != ~^in_data).
REQ-019 A byte SHALL be accepted on a cycle with in_valid && in_ready.
REQ-020 in_ready SHALL be 1 in IDLE and RECV and 0 in DONE and during reset.
REQ-021 FSM states SHALL be IDLE, RECV and DONE.
  - IDLE->RECV on an accepted byte when PKT_LEN>1.
  - IDLE->DONE on an accepted byte when PKT_LEN==1.
  - RECV->DONE on acceptance of byte number PKT_LEN.
  - DONE->IDLE unconditionally after one cycle.
REQ-022 out_valid/out_data/out_par/out_err SHALL be registered, asserted exactly 1 cycle after acceptance, out_valid low otherwise; out_data/out_par/out_err SHALL hold their last values when out_valid is low.
REQ-023 A byte-index counter SHALL reset to 0 at packet start and increment per accepted byte; no wrap beyond PKT_LEN-1.
REQ-024 A sticky packet-error flag SHALL set on any bad byte and clear on entering IDLE.
REQ-025 pkt_done SHALL be high only in DONE, i.e. the cycle coinciding with out_valid of the last byte; pkt_err SHALL be the sticky flag including the last byte, and 0 whenever pkt_done is 0.
REQ-026 err_cnt SHALL increment by 1 per bad byte, registered with out_valid, and saturate at 2^CNT_W-1 with no wrap.
REQ-027 clr_cnt SHALL zero err_cnt next cycle and SHALL win over a simultaneous increment.
REQ-028 Idle gaps (in_valid low) inside a packet SHALL stay in RECV with no timeout.
REQ-029 A new packet's first byte SHALL NOT be accepted in DONE; it is accepted at earliest the following cycle, in IDLE.

Reset
REQ-030 On rst, state SHALL go to IDLE and the byte index and sticky flag SHALL clear.
REQ-031 On rst, outputs SHALL be: out_valid=0, out_data=0, out_par=0, out_err=0, pkt_done=0, pkt_err=0, err_cnt=0, busy=0; in_ready=0 while rst is high.
REQ-032 Reset mid-packet SHALL discard the partial packet with no pkt_done strobe.

Structure
REQ-033 State encodings (IDLE/RECV/DONE) SHALL live in a shared package parity_pkg, together with the odd-parity convention constant (PAR_ODD=1).
REQ-034 Byte parity compute/compare SHALL be one combinational sub-module, parity_gen_chk (data_in, parity_in -> parity_out, error), instantiated once; FSM, counters and registers SHALL be in parity_pkt_ctrl.

Verification
REQ-035 Clean packet, PKT_LEN=4: bytes 0x55/1, 0xAA/1, 0xF0/1, 0x0F/1 back-to-back -> four out_valid with out_err=0, out_par=1; pkt_done at the 4th; pkt_err=0; err_cnt=0.
REQ-036 Single bad byte: 0x01/1 as byte 2 (0x01 has odd ones, so par should be 0) -> out_err=1 on that byte only; pkt_err=1 at pkt_done; err_cnt=1.
REQ-037 Handshake: hold in_valid high across two packets -> in_ready=0 for exactly 1 cycle (DONE) between packets; no byte lost or duplicated.
REQ-038 Saturation with CNT_W=2: 5 bad bytes -> err_cnt sequence 1,2,3,3,3; then clr_cnt asserted together with a bad byte -> err_cnt=0.
REQ-039 Reset mid-packet: rst after byte 2 -> no pkt_done; next 4 bytes form a fresh packet with pkt_done on the 4th and pkt_err from those 4 bytes only.
REQ-040 Gaps: 3-cycle in_valid gap inside a packet -> busy stays 1; pkt_done is still asserted after the 4th accepted byte.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity packet controller: FSM state encoding,
// the odd-parity convention and the parity helper built on it.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic PAR_ODD = 1'b1;

    // Parity bit that makes the total number of ones odd when PAR_ODD is set
    function automatic logic odd_parity(input logic [7:0] data);
        return (^data) ^ PAR_ODD;
    endfunction

endpackage

// File: rtl/parity_gen_chk.sv
// Combinational byte parity generator and checker: regenerates the expected
// parity bit and flags a mismatch against the received one.
module parity_gen_chk
    import parity_pkg::*;
(
    input  logic [7:0] data_in,
    input  logic       parity_in,
    output logic       parity_out,
    output logic       error
);

    assign parity_out = odd_parity(data_in);
    assign error      = (parity_in != parity_out);

endmodule

// File: rtl/parity_pkt_ctrl.sv
// Packet-framed parity checker: passes bytes through with regenerated parity,
// frames them into PKT_LEN-byte packets and keeps a saturating error count.
module parity_pkt_ctrl
    import parity_pkg::*;
#(
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_par,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_par,
    output logic             out_err,
    output logic             pkt_done,
    output logic             pkt_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    localparam logic [7:0]       LAST_IDX = 8'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_par_q;
    logic             out_err_q;
    logic             accept_s;
    logic             par_s;
    logic             err_s;

    parity_gen_chk u_par (
        .data_in    (in_data),
        .parity_in  (in_par),
        .parity_out (par_s),
        .error      (err_s)
    );

    assign in_ready = (state_q != DONE) && !rst;
    assign accept_s = in_valid && in_ready;

    // Next-state, byte index and sticky packet-error logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sticky_d = sticky_q;
        case (state_q)
            IDLE: begin
                idx_d    = 8'd0;
                sticky_d = 1'b0;
                if (accept_s) begin
                    sticky_d = err_s;
                    if (LAST_IDX == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RECV;
                        idx_d   = 8'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (accept_s) begin
                    sticky_d = sticky_q | err_s;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    state_d = RECV;
                end
            end
            DONE: begin
                state_d  = IDLE;
                idx_d    = 8'd0;
                sticky_d = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                idx_d    = 8'd0;
                sticky_d = 1'b0;
            end
        endcase
    end

    // Error counter: clear has priority over increment, increment saturates
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (accept_s && err_s && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, counters and registered byte outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 8'd0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_par_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sticky_q    <= sticky_d;
            err_cnt_q   <= err_cnt_d;
            out_valid_q <= accept_s;
            if (accept_s) begin
                out_data_q <= in_data;
                out_par_q  <= par_s;
                out_err_q  <= err_s;
            end else begin
                out_data_q <= out_data_q;
                out_par_q  <= out_par_q;
                out_err_q  <= out_err_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_par   = out_par_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;
    assign pkt_done  = (state_q == DONE);
    assign pkt_err   = (state_q == DONE) && sticky_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_parity_pkt_ctrl.sv
// Randomized and directed bench for parity_pkt_ctrl: two instances share one
// stimulus stream and are compared every cycle against a packet-level model.
module tb_parity_pkt_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_par;
    logic       clr_cnt;

    logic [1:0] rdy_w, ov_w, opar_w, oerr_w, done_w, perr_w, busy_w;
    logic [7:0] od_w [2];
    logic [7:0] cnt0_w;
    logic [1:0] cnt1_w;

    int total = 0;
    int bad   = 0;

    // model state, index 0: PKT_LEN=4 CNT_W=8, index 1: PKT_LEN=1 CNT_W=2
    int   m_len [2] = '{4, 1};
    int   m_max [2] = '{255, 3};
    int   m_n   [2];
    bit   m_blk [2];
    bit   m_acc [2];
    bit   e_ov [2], e_opar [2], e_oerr [2], e_done [2], e_perr [2], e_busy [2];
    logic [7:0] e_od [2];
    int   e_cnt [2];
    int   rdy_low_cnt;
    int   ov_cnt;
    int   sat_seq [5] = '{1, 2, 3, 3, 3};

    parity_pkt_ctrl #(.PKT_LEN(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[0]),
        .in_data(in_data), .in_par(in_par), .clr_cnt(clr_cnt),
        .out_valid(ov_w[0]), .out_data(od_w[0]), .out_par(opar_w[0]),
        .out_err(oerr_w[0]), .pkt_done(done_w[0]), .pkt_err(perr_w[0]),
        .err_cnt(cnt0_w), .busy(busy_w[0])
    );

    parity_pkt_ctrl #(.PKT_LEN(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[1]),
        .in_data(in_data), .in_par(in_par), .clr_cnt(clr_cnt),
        .out_valid(ov_w[1]), .out_data(od_w[1]), .out_par(opar_w[1]),
        .out_err(oerr_w[1]), .pkt_done(done_w[1]), .pkt_err(perr_w[1]),
        .err_cnt(cnt1_w), .busy(busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One model cycle for instance k using the inputs currently applied
    task automatic model_step(input int k);
        bit acc, bad_b, exp_rdy;
        exp_rdy = !rst && !m_blk[k];
        check_val($sformatf("ready%0d", k), 32'(rdy_w[k]), 32'(exp_rdy));
        if (rst) begin
            m_n[k] = 0; m_blk[k] = 0; m_acc[k] = 0;
            e_ov[k] = 0; e_od[k] = 8'h00; e_opar[k] = 0; e_oerr[k] = 0;
            e_done[k] = 0; e_perr[k] = 0; e_cnt[k] = 0; e_busy[k] = 0;
        end else begin
            acc   = in_valid && exp_rdy;
            bad_b = (in_par != ~^in_data);
            e_ov[k] = acc;
            if (acc) begin
                e_od[k] = in_data; e_opar[k] = ~^in_data; e_oerr[k] = bad_b;
            end
            if (clr_cnt) e_cnt[k] = 0;
            else if (acc && bad_b && e_cnt[k] < m_max[k]) e_cnt[k]++;
            e_done[k] = 0; e_perr[k] = 0;
            if (m_blk[k]) begin
                m_blk[k] = 0;
            end else if (acc) begin
                m_acc[k] = m_acc[k] | bad_b;
                m_n[k]++;
                if (m_n[k] == m_len[k]) begin
                    e_done[k] = 1; e_perr[k] = m_acc[k];
                    m_blk[k] = 1; m_n[k] = 0; m_acc[k] = 0;
                end
            end
            e_busy[k] = (m_n[k] > 0) || m_blk[k];
        end
    endtask

    task automatic compare_outputs(input int k);
        check_val($sformatf("out_valid%0d", k), 32'(ov_w[k]), 32'(e_ov[k]));
        check_val($sformatf("out_data%0d", k), 32'(od_w[k]), 32'(e_od[k]));
        check_val($sformatf("out_par%0d", k), 32'(opar_w[k]), 32'(e_opar[k]));
        check_val($sformatf("out_err%0d", k), 32'(oerr_w[k]), 32'(e_oerr[k]));
        check_val($sformatf("pkt_done%0d", k), 32'(done_w[k]), 32'(e_done[k]));
        check_val($sformatf("pkt_err%0d", k), 32'(perr_w[k]), 32'(e_perr[k]));
        check_val($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(e_busy[k]));
        if (k == 0) check_val("err_cnt0", 32'(cnt0_w), 32'(e_cnt[0]));
        else        check_val("err_cnt1", 32'(cnt1_w), 32'(e_cnt[1]));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic p,
                        input logic c, input logic r);
        in_valid = v; in_data = d; in_par = p; clr_cnt = c; rst = r;
        #1;
        if (v && !rdy_w[0]) rdy_low_cnt++;
        model_step(0);
        model_step(1);
        @(negedge clk);
        if (ov_w[0]) ov_cnt++;
        compare_outputs(0);
        compare_outputs(1);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic good_byte(input logic [7:0] d);
        step(1'b1, d, ~^d, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("rst_cnt", 32'(cnt0_w), 32'd0);
        check_val("rst_busy", 32'(busy_w[0]), 32'd0);

        // clean packet
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
        check_val("clean_done", 32'(done_w[0]), 32'd1);
        check_val("clean_perr", 32'(perr_w[0]), 32'd0);
        check_val("clean_par", 32'(opar_w[0]), 32'd1);
        idle();

        // single bad byte as byte 2
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        check_val("bad_oerr", 32'(oerr_w[0]), 32'd1);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
        check_val("bad_perr", 32'(perr_w[0]), 32'd1);
        check_val("bad_cnt", 32'(cnt0_w), 32'd1);
        idle();

        // valid held across two packets
        rdy_low_cnt = 0; ov_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            d = 8'($urandom);
            good_byte(d);
        end
        check_val("hs_ready_low", 32'(rdy_low_cnt), 32'd1);
        check_val("hs_bytes", 32'(ov_cnt), 32'd8);
        idle();

        // saturation on the CNT_W=2 instance, then clear against a bad byte
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
            check_val("sat_seq", 32'(cnt1_w), 32'(sat_seq[i]));
            idle();
        end
        step(1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
        check_val("sat_clr", 32'(cnt1_w), 32'd0);
        idle();
        idle();

        // reset mid-packet, then a fresh packet
        good_byte(8'h11);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        good_byte(8'h44);
        good_byte(8'h55);
        good_byte(8'h66);
        check_val("rstmid_nodone", 32'(done_w[0]), 32'd0);
        good_byte(8'h77);
        check_val("rstmid_done", 32'(done_w[0]), 32'd1);
        check_val("rstmid_perr", 32'(perr_w[0]), 32'd0);
        idle();

        // gap inside a packet
        good_byte(8'h81);
        good_byte(8'h82);
        for (int i = 0; i < 3; i++) begin
            idle();
            check_val("gap_busy", 32'(busy_w[0]), 32'd1);
        end
        good_byte(8'h83);
        good_byte(8'h84);
        check_val("gap_done", 32'(done_w[0]), 32'd1);
        idle();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            d = 8'($urandom);
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, d,
                 ($urandom_range(0, 3) == 0) ? ^d : ~^d,
                 ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
